asic_andn_pipe: RTL and testbench
=================================

Name: asic_andn_pipe

Overview:
- Parametrised N-input AND-reduction built as a tree of 4-input AND leaf cells.
- Optional pipeline register after every tree level, with valid/ready flow control and per-lane masking.
- Replaces ad-hoc chains of fixed-width AND cells in wide "all-ready", "all-done" and match-detect paths where timing needs registering.
- Sits between producer and consumer logic in the same clock domain.

Parameters:
- N, 16, number of input lanes; legal range 2..256.
- PIPE, 1, 1 = register after every tree level; 0 = fully combinational tree, still with the handshake ports.
- PROP, "DEFAULT", implementation property string passed unchanged to every leaf cell.
- Derived constant L = ceil(log4(N)), the number of tree levels. N=16 gives L=2; N=5 gives L=2; N=64 gives L=3.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- nreset  input  1  asynchronous active-low reset.
- in_valid  input  1  the in/mask pair is valid this cycle.
- in_ready  output  1  block accepts in/mask this cycle.
- in  input  N  lanes to be reduced.
- mask  input  N  1 = lane participates; 0 = lane is forced to 1 before reduction.
- out_valid  output  1  z is valid.
- out_ready  input  1  consumer accepts z this cycle.
- z  output  1  AND of (in | ~mask) over all N lanes.

Behaviour:
- Reset: asserting nreset low asynchronously clears every stage valid bit and every stage data register. Outputs during and after reset: out_valid=0, z=0, in_ready=1.
- Width rule: at each level, pad the operand vector with 1s up to a multiple of 4, then reduce each group of 4 with one leaf cell. Level k output width is ceil(width_(k-1)/4). The final level output is 1 bit.
- Masking is applied combinationally before level 1: lane_i = in[i] | ~mask[i].
- mask all zero gives z=1. in all zero with mask all ones gives z=0.
- PIPE=1:
  - Stage k holds register data_k and flag v_k, for k = 1..L.
  - adv_L = ~v_L | out_ready.
  - adv_k = ~v_k | adv_(k+1), for k < L.
  - in_ready = adv_1. This is a combinational path from out_ready.
  - On adv_k: v_k <= valid of the previous stage (in_valid for k=1); data_k <= reduced data of the previous stage.
  - out_valid = v_L; z = data_L.
  - Latency is L cycles from accepted input to out_valid.
  - Throughput is 1 result per cycle while out_ready=1.
  - Bubbles compress: a stage with v_k=0 always loads.
- PIPE=0:
  - Latency 0: out_valid = in_valid, in_ready = out_ready, z is combinational from in and mask.
  - nreset has no effect on outputs in this mode.
- Stall: while out_valid=1 and out_ready=0, z and out_valid hold stable. Upstream stages keep filling until each holds valid data; then in_ready=0.
- Transfer rule: a transfer occurs only when valid and ready are both 1 in the same cycle. Data presented while in_ready=0 is not captured.
- Simultaneous input accept and output drain in one cycle is lossless, with no duplication.
- Reset mid-operation: all in-flight results are discarded. No spurious out_valid after reset release.
- Data is X-free after reset. No output depends on an uninitialised register.

Decomposition:
- Shared package: function clog4(n) computing L; function level_width(n,k) giving ceil(n/4^k).
- Leaf sub-module: asic_and4, instantiated per 4-lane group via generate, with PROP passed through.
- Pipeline stage logic stays inline in generate loops. No separate stage module.

Test Plan:
- N=16, PIPE=1: reset, then in=16'hFFFF, mask=16'hFFFF, one-cycle in_valid, out_ready=1 -> out_valid pulses exactly 2 cycles later with z=1; then idle with out_valid=0.
- N=16, PIPE=1: back-to-back inputs 16'hFFFF, 16'hFFFE, 16'hFFFF with mask=all ones and out_ready=1 -> z sequence 1,0,1 on three consecutive out_valid cycles starting at cycle 2.
- N=16: in=16'h00F0, mask=16'h00F0 -> z=1. Then mask=16'h01F0 -> z=0.
- N=16, PIPE=1: hold out_ready=0 with continuous in_valid -> in_ready drops after 2 accepts, z holds. Raise out_ready -> both results delivered in order; no loss, no duplicates.
- N=5, PIPE=1: in=5'b11111 -> z=1; in=5'b01111 -> z=0. Checks padding; latency 2.
- N=16, PIPE=1: pulse nreset low while 2 results are in flight -> out_valid=0, z=0 immediately. No out_valid for L cycles after release unless new input is accepted.

Source files
------------

// File: rtl/asic_andn_pipe_pkg.sv
// Shared sizing helpers for the AND-reduction tree: level count and per-level widths.
package asic_andn_pipe_pkg;

  localparam int LEAF_WIDTH = 4;

  // Number of 4:1 tree levels needed to reduce n lanes to one bit.
  function automatic int clog4(input int n);
    int levels;
    int span;
    levels = 0;
    span   = 1;
    while (span < n) begin
      span   = span * LEAF_WIDTH;
      levels = levels + 1;
    end
    return levels;
  endfunction

  // Width of the vector after k levels of reduction: ceil(n / 4^k).
  function automatic int level_width(input int n, input int k);
    int div;
    div = 1;
    for (int i = 0; i < k; i++) begin
      div = div * LEAF_WIDTH;
    end
    return (n + div - 1) / div;
  endfunction

endpackage

// File: rtl/asic_and4.sv
// 4-input AND leaf cell; PROP selects the implementation variant in technology mapping.
module asic_and4 #(
  parameter string PROP = "DEFAULT"
) (
  input  logic [3:0] a,
  output logic       z
);

  assign z = &a;

endmodule

// File: rtl/asic_andn_pipe.sv
// N-lane masked AND reduction built from 4-input leaf cells, with an optional
// valid/ready register stage after every tree level.
module asic_andn_pipe
  import asic_andn_pipe_pkg::*;
#(
  parameter int    N    = 16,
  parameter int    PIPE = 1,
  parameter string PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in,
  input  logic [N-1:0] mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         z
);

  localparam int L = clog4(N);

  logic [L:1]   v_reg;
  logic [L:0]   v_chain;
  logic [L+1:1] adv;

  genvar gi, gj;

  if (PIPE != 0) begin : g_flow
    assign v_chain  = {v_reg, in_valid};
    assign adv[L+1] = out_ready;

    // A stage advances when it, or every stage downstream of it, can drain.
    for (gi = 1; gi <= L; gi++) begin : g_adv
      assign adv[gi] = out_ready | ~(&v_reg[L:gi]);
    end

    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        v_reg <= '0;
      end else begin
        for (int k = 1; k <= L; k++) begin
          if (adv[k]) begin
            v_reg[k] <= v_chain[k-1];
          end
        end
      end
    end

    assign in_ready  = adv[1];
    assign out_valid = v_reg[L];
  end else begin : g_comb_flow
    assign v_reg     = '0;
    assign v_chain   = '0;
    assign adv       = '1;
    assign in_ready  = out_ready;
    assign out_valid = in_valid;
  end

  for (gi = 0; gi <= L; gi++) begin : lvl
    localparam int W = level_width(N, gi);
    logic [W-1:0] data;

    if (gi == 0) begin : g_src
      // Masked-off lanes read as 1 so they cannot pull the result low.
      assign data = in | ~mask;
    end else begin : g_red
      localparam int WP = level_width(N, gi - 1);
      logic [4*W-1:0] padded;
      logic [W-1:0]   reduced;

      always_comb begin
        padded         = '1;
        padded[WP-1:0] = lvl[gi-1].data;
      end

      for (gj = 0; gj < W; gj++) begin : g_leaf
        asic_and4 #(.PROP(PROP)) u_and4 (
          .a (padded[4*gj +: 4]),
          .z (reduced[gj])
        );
      end

      if (PIPE != 0) begin : g_reg
        logic [W-1:0] data_reg;

        always_ff @(posedge clk or negedge nreset) begin
          if (!nreset) begin
            data_reg <= '0;
          end else if (adv[gi]) begin
            data_reg <= reduced;
          end
        end

        assign data = data_reg;
      end else begin : g_wire
        assign data = reduced;
      end
    end
  end

  assign z = lvl[L].data[0];

endmodule

// File: tb/tb_asic_andn_pipe.sv
// Self-checking bench for asic_andn_pipe: constant table, directed latency/stall/reset
// sequences, and a randomized scoreboard run against a lane-by-lane reference.
module tb_asic_andn_pipe;

  logic        clk = 1'b0;
  logic        nreset;
  logic        iv, ordy;
  logic [15:0] din, dmask;
  logic        irdy, ov, zz;
  logic        iv5, ordy5;
  logic [4:0]  din5, dmask5;
  logic        irdy5, ov5, z5;
  logic        irdy0, ov0, z0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  asic_andn_pipe #(.N(16), .PIPE(1), .PROP("DEFAULT")) dut (
    .clk(clk), .nreset(nreset), .in_valid(iv), .in_ready(irdy), .in(din), .mask(dmask),
    .out_valid(ov), .out_ready(ordy), .z(zz)
  );

  asic_andn_pipe #(.N(5), .PIPE(1), .PROP("DEFAULT")) dut5 (
    .clk(clk), .nreset(nreset), .in_valid(iv5), .in_ready(irdy5), .in(din5), .mask(dmask5),
    .out_valid(ov5), .out_ready(ordy5), .z(z5)
  );

  asic_andn_pipe #(.N(16), .PIPE(0), .PROP("DEFAULT")) dut0 (
    .clk(clk), .nreset(nreset), .in_valid(iv), .in_ready(irdy0), .in(din), .mask(dmask),
    .out_valid(ov0), .out_ready(ordy), .z(z0)
  );

  typedef struct {
    logic [15:0] in_v;
    logic [15:0] mask_v;
    logic        exp_z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: result is 1 unless some participating lane is 0.
  function automatic logic ref_and(input logic [15:0] a, input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      if (m[i] && !a[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    iv = 0; ordy = 1; iv5 = 0; ordy5 = 1;
    din = '0; dmask = '1; din5 = '0; dmask5 = '1;
    nreset = 0;
    tick();
    tick();
    nreset = 1;
  endtask

  task automatic pulse5(input logic [4:0] d, input logic req_z, input string name);
    reset_dut();
    iv5 = 1; din5 = d; dmask5 = '1;
    tick();
    iv5 = 0;
    @(negedge clk);
    chk({name, "_lat1_valid"}, ov5, 0);
    tick();
    @(negedge clk);
    chk({name, "_lat2_valid"}, ov5, 1);
    chk({name, "_z"}, z5, req_z);
    $display("txn n5 in=%b z=%0b", d, z5);
  endtask

  initial begin
    vec_t tbl[8];
    logic exp_q[$];
    logic exp_z;
    logic [15:0] seq[3];
    int accepts, got;
    logic prev_stall, prev_z;

    tbl[0] = '{16'h00F0, 16'h00F0, 1'b1};
    tbl[1] = '{16'h00F0, 16'h01F0, 1'b0};
    tbl[2] = '{16'hFFFF, 16'h0000, 1'b1};
    tbl[3] = '{16'h0000, 16'hFFFF, 1'b0};
    tbl[4] = '{16'h0000, 16'h0000, 1'b1};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1};
    tbl[6] = '{16'h7FFF, 16'hFFFF, 1'b0};
    tbl[7] = '{16'h8000, 16'h8000, 1'b1};

    // Reset state, sampled during and after reset.
    iv = 0; ordy = 1; iv5 = 0; ordy5 = 1; din = '0; dmask = '1; din5 = '0; dmask5 = '1;
    nreset = 0;
    #2;
    chk("reset_out_valid", ov, 0);
    chk("reset_z", zz, 0);
    chk("reset_in_ready", irdy, 1);
    reset_dut();
    @(negedge clk);
    chk("post_reset_out_valid", ov, 0);
    chk("post_reset_z", zz, 0);

    // Combinational variant: masking table and pass-through handshake.
    for (int i = 0; i < 8; i++) begin
      din = tbl[i].in_v; dmask = tbl[i].mask_v;
      iv = 1'($urandom_range(0, 1)); ordy = 1'($urandom_range(0, 1));
      #1;
      chk("comb_z", z0, tbl[i].exp_z);
      chk("comb_out_valid", ov0, iv);
      chk("comb_in_ready", irdy0, ordy);
      $display("txn comb in=%h mask=%h z=%0b", din, dmask, z0);
    end

    // Single accepted input appears exactly two cycles later, then idle.
    reset_dut();
    iv = 1; din = 16'hFFFF; dmask = 16'hFFFF; ordy = 1;
    @(negedge clk);
    chk("pulse_in_ready", irdy, 1);
    tick();
    iv = 0;
    @(negedge clk);
    chk("pulse_lat1_valid", ov, 0);
    tick();
    @(negedge clk);
    chk("pulse_lat2_valid", ov, 1);
    chk("pulse_z", zz, 1);
    tick();
    @(negedge clk);
    chk("pulse_idle_valid", ov, 0);

    // Back-to-back inputs at full throughput.
    seq[0] = 16'hFFFF; seq[1] = 16'hFFFE; seq[2] = 16'hFFFF;
    reset_dut();
    dmask = '1; ordy = 1;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        iv = 1; din = seq[c];
      end else begin
        iv = 0;
      end
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        chk("b2b_valid", ov, 1);
        chk("b2b_z", zz, ref_and(seq[c-2], 16'hFFFF, 16));
        $display("txn b2b z=%0b", zz);
      end else begin
        chk("b2b_gap_valid", ov, 0);
      end
      tick();
    end

    // Stall: two accepts fill the pipe, output holds, then drains in order.
    reset_dut();
    exp_q.delete();
    ordy = 0; iv = 1; dmask = '1; accepts = 0;
    for (int c = 0; c < 6; c++) begin
      din = (accepts % 2 == 0) ? 16'h0000 : 16'hFFFF;
      @(negedge clk);
      if (irdy) begin
        exp_q.push_back(ref_and(din, dmask, 16));
        accepts++;
      end
      tick();
    end
    chk("stall_accepts", accepts, 2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_in_ready", irdy, 0);
      chk("stall_valid", ov, 1);
      chk("stall_z", zz, 0);
      tick();
    end
    iv = 0; ordy = 1; got = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ov) begin
        if (exp_q.size() == 0) begin
          chk("stall_extra_output", 1, 0);
        end else begin
          exp_z = exp_q.pop_front();
          chk("stall_drain_z", zz, exp_z);
        end
        got++;
        $display("txn drain z=%0b", zz);
      end
      tick();
    end
    chk("stall_delivered", got, 2);

    // Padding: 5 lanes, two levels.
    pulse5(5'b11111, 1'b1, "n5_ones");
    pulse5(5'b01111, 1'b0, "n5_msb0");

    // Reset with two results in flight.
    reset_dut();
    ordy = 0; iv = 1; din = 16'hFFFF; dmask = '1;
    tick();
    tick();
    iv = 0;
    @(negedge clk);
    chk("midrst_full_valid", ov, 1);
    #1 nreset = 0;
    #1;
    chk("midrst_out_valid", ov, 0);
    chk("midrst_z", zz, 0);
    chk("midrst_in_ready", irdy, 1);
    tick();
    nreset = 1; ordy = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_no_spurious", ov, 0);
      tick();
    end

    // Randomized run against the scoreboard.
    reset_dut();
    exp_q.delete();
    prev_stall = 0; prev_z = 0;
    for (int c = 0; c < 400; c++) begin
      iv    = ($urandom % 4) != 0;
      ordy  = ($urandom % 3) != 0;
      dmask = 16'($urandom);
      din   = ($urandom % 2 == 0) ? 16'hFFFF : ~(16'h1 << $urandom_range(0, 15));
      @(negedge clk);
      chk("rand_in_ready", irdy, ordy || (exp_q.size() < 2));
      if (exp_q.size() == 0) chk("rand_idle_valid", ov, 0);
      if (exp_q.size() == 2) chk("rand_full_valid", ov, 1);
      if (prev_stall) begin
        chk("rand_stall_valid", ov, 1);
        chk("rand_stall_z", zz, prev_z);
      end
      if (ov && ordy && exp_q.size() != 0) begin
        exp_z = exp_q.pop_front();
        chk("rand_z", zz, exp_z);
        $display("txn rand cycle=%0d z=%0b", c, zz);
      end
      if (iv && irdy) exp_q.push_back(ref_and(din, dmask, 16));
      prev_stall = ov && !ordy;
      prev_z = zz;
      tick();
    end
    iv = 0; ordy = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ov && exp_q.size() != 0) begin
        exp_z = exp_q.pop_front();
        chk("rand_drain_z", zz, exp_z);
        $display("txn rand_drain z=%0b", zz);
      end
      tick();
    end
    chk("rand_drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
